// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline.
package pipe_pkg;

  localparam int unsigned PIPE_MIN_DEPTH = 1;

  // Bits needed to hold an occupancy of 0..depth.
  function automatic int pipe_cw(int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_elastic_stage.sv
// One elastic stage: loads from upstream whenever it is empty or downstream advances.
// Optional flush input when PIPE_ELASTIC_FLUSH_EN is defined.
module pipe_elastic_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_vld,
  input  logic             dn_rdy,
`ifdef PIPE_ELASTIC_FLUSH_EN
  input  logic             flush,
`endif
  output logic [WIDTH-1:0] data,
  output logic             vld,
  output logic             rdy
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             vld_d, vld_q;
  logic             kill;

`ifdef PIPE_ELASTIC_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  assign rdy  = !vld_q | dn_rdy;
  assign data = data_q;
  assign vld  = vld_q;

  // Bubbles keep stale data; flush drops valid but leaves data untouched.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (kill) begin
      vld_d = 1'b0;
    end else if (rdy) begin
      vld_d = up_vld;
      if (up_vld) begin
        data_d = up_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: rtl/pipe_elastic.sv
// Elastic DEPTH-stage pipeline with valid/ready on both sides and registered occupancy.
// Optional synchronous flush port enabled by PIPE_ELASTIC_FLUSH_EN.
module pipe_elastic
  import pipe_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 3,
  localparam int unsigned CW    = unsigned'(pipe_cw(int'(DEPTH)))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_in_valid,
  output logic             d_in_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             d_out_valid,
  input  logic             d_out_ready,
`ifdef PIPE_ELASTIC_FLUSH_EN
  input  logic             flush,
`endif
  output logic [CW-1:0]    count
);

  if (DEPTH < PIPE_MIN_DEPTH || WIDTH < 1) begin : g_bad_cfg
    $error("pipe_elastic: WIDTH and DEPTH must both be at least 1");
  end

  logic [WIDTH-1:0] sdata [DEPTH];
  logic [DEPTH-1:0] svld;
  logic [DEPTH-1:0] stg_rdy;
  logic [DEPTH:0]   rdy_c;
  logic             kill;
  logic             in_fire;
  logic             out_fire;
  logic [CW-1:0]    count_d, count_q;
  logic             unused_rdy;

`ifdef PIPE_ELASTIC_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  // Ready chain resolved in one process so it stays acyclic at signal level.
  always_comb begin
    rdy_c        = '0;
    rdy_c[DEPTH] = d_out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      rdy_c[i] = !svld[i] | rdy_c[i+1];
    end
  end

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
    logic [WIDTH-1:0] up_data;
    logic             up_vld;

    if (i == 0) begin : g_head
      assign up_data = d_in;
      assign up_vld  = d_in_valid;
    end else begin : g_body
      assign up_data = sdata[i-1];
      assign up_vld  = svld[i-1];
    end

    pipe_elastic_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .up_data (up_data),
      .up_vld  (up_vld),
      .dn_rdy  (rdy_c[i+1]),
`ifdef PIPE_ELASTIC_FLUSH_EN
      .flush   (flush),
`endif
      .data    (sdata[i]),
      .vld     (svld[i]),
      .rdy     (stg_rdy[i])
    );
  end

  assign unused_rdy  = ^{stg_rdy, rdy_c[0]};
  assign d_in_ready  = stg_rdy[0] & !kill;
  assign d_out       = sdata[DEPTH-1];
  assign d_out_valid = svld[DEPTH-1];
  assign in_fire     = d_in_valid & d_in_ready;
  assign out_fire    = d_out_valid & d_out_ready & !kill;
  assign count       = count_q;

  // Occupancy tracks fires so it never depends on the ready chain at the output.
  always_comb begin
    count_d = count_q;
    if (kill) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(in_fire) - CW'(out_fire);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
